// File: rtl/seg_scan_disp_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seg_scan_disp display stage: active-low
// seven-segment glyphs ({g,f,e,d,c,b,a}), the digit index type, the
// all-digits-off enable pattern and a one-hot-low digit enable helper.
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_U     = 7'b1000001;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;

    localparam logic [3:0] AN_ALL_OFF  = 4'b1111;

    // Standard hex glyphs, active-low gfedcba, indexed by nibble value.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    typedef enum logic [1:0] {
        DIG_Q      = 2'd0,   // counter value
        DIG_CNT_LO = 2'd1,   // carry count, low nibble
        DIG_CNT_HI = 2'd2,   // carry count, high nibble
        DIG_DIR    = 2'd3    // direction letter
    } digit_t;

    function automatic logic [3:0] onehot_n(input digit_t d);
        onehot_n = ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg_scan_disp_hex2seg.sv
// ---------------------------------------------------------------------------
// hex2seg
// Combinational 4-bit value to active-low seven-segment glyph decoder.
// Ports:
//   i_val  in  4  nibble to display
//   o_seg  out 7  glyph {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex2seg
    import seg_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = HEX_GLYPH[i_val];
    end

endmodule

// File: rtl/seg_scan_disp.sv
// ---------------------------------------------------------------------------
// seg_scan_disp
// Multiplexed 4-digit common-anode seven-segment display stage for the
// up/down counter. Digit 0 shows the counter value, digits 1/2 an 8-bit
// count of qualified carry (wrap) events, digit 3 the direction (U/d).
// All outputs are registered; one digit slot lasts SCAN_DIV clocks.
//
// Optional feature macro: SEG_CARRY_BLINK_EN
//   defined   - each counted carry lights the decimal point on digit 0 for
//               BLINK_TICKS scan ticks (retriggerable)
//   undefined - no stretch counter, seg_dp held at 1
//
// Ports:
//   clk      in  1  system clock, rising edge
//   reset_n  in  1  asynchronous active-low reset
//   q        in  4  counter value
//   z_carry  in  1  counter carry flag
//   en       in  1  counter enable
//   dir      in  1  counter direction, 1 = up
//   clr      in  1  synchronous clear of the carry count
//   seg_an   out 4  digit enables, one-hot active-low
//   seg      out 7  segments {g,f,e,d,c,b,a}, active-low
//   seg_dp   out 1  decimal point, active-low
// ---------------------------------------------------------------------------
module seg_scan_disp
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLINK_TICKS = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] q,
    input  logic       z_carry,
    input  logic       en,
    input  logic       dir,
    input  logic       clr,
    output logic [3:0] seg_an,
    output logic [6:0] seg,
    output logic       seg_dp
);

    localparam int unsigned         PRE_W   = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    digit_t           r_sel;
    logic             r_run;
    logic             r_en_q;
    logic [7:0]       r_cnt;
    logic [3:0]       r_seg_an;
    logic [6:0]       r_seg;
    logic             r_seg_dp;

    logic             w_tick;
    digit_t           w_sel_next;
    logic             w_run_next;
    logic             w_carry;
    logic [3:0]       w_hex_val;
    logic [6:0]       w_hex_glyph;
    logic [6:0]       w_glyph;
    logic             w_dp_lit;

    assign w_tick     = (r_pre == PRE_MAX);
    assign w_sel_next = w_tick ? digit_t'(r_sel + 2'd1) : r_sel;
    assign w_run_next = r_run | w_tick;

    // A held carry flag is only a new wrap if the counter advanced at the
    // previous edge.
    assign w_carry    = z_carry & r_en_q;

    always_comb begin
        w_hex_val = q;
        unique case (w_sel_next)
            DIG_Q:      w_hex_val = q;
            DIG_CNT_LO: w_hex_val = r_cnt[3:0];
            DIG_CNT_HI: w_hex_val = r_cnt[7:4];
            DIG_DIR:    w_hex_val = q;
        endcase
    end

    hex2seg u_hex2seg (
        .i_val (w_hex_val),
        .o_seg (w_hex_glyph)
    );

    always_comb begin
        w_glyph = w_hex_glyph;
        if (w_sel_next == DIG_DIR) begin
            w_glyph = dir ? GLYPH_U : GLYPH_D;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre  <= '0;
            r_sel  <= DIG_DIR;
            r_run  <= 1'b0;
            r_en_q <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_pre  <= w_tick ? '0 : r_pre + 1'b1;
            r_sel  <= w_sel_next;
            r_run  <= w_run_next;
            r_en_q <= en;
            if (clr) begin
                r_cnt <= '0;
            end else if (w_carry) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

`ifdef SEG_CARRY_BLINK_EN
    logic [7:0] r_stretch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stretch <= '0;
        end else if (w_carry) begin
            r_stretch <= 8'(BLINK_TICKS);
        end else if (w_tick && (r_stretch != 8'd0)) begin
            r_stretch <= r_stretch - 8'd1;
        end
    end

    assign w_dp_lit = (w_sel_next == DIG_Q) && (r_stretch != 8'd0);
`else
    // Decimal point never lit; BLINK_TICKS only sizes the stretch when
    // blinking is built in.
    localparam logic BLINK_CFG_OK = (BLINK_TICKS >= 1) && (BLINK_TICKS <= 255);
    assign w_dp_lit = 1'b0 & BLINK_CFG_OK;
`endif

    // Enables and segments load from sel_next on the same edge, so a digit
    // never shows its neighbour's glyph.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg_an <= AN_ALL_OFF;
            r_seg    <= GLYPH_BLANK;
            r_seg_dp <= 1'b1;
        end else if (w_run_next) begin
            r_seg_an <= onehot_n(w_sel_next);
            r_seg    <= w_glyph;
            r_seg_dp <= ~w_dp_lit;
        end else begin
            r_seg_an <= AN_ALL_OFF;
            r_seg    <= GLYPH_BLANK;
            r_seg_dp <= 1'b1;
        end
    end

    assign seg_an = r_seg_an;
    assign seg    = r_seg;
    assign seg_dp = r_seg_dp;

endmodule

// File: tb/tb_seg_scan_disp.sv
module tb_seg_scan_disp;

    logic       clk;
    logic       reset_n;
    logic [3:0] q;
    logic       z_carry;
    logic       en;
    logic       dir;
    logic       clr;
    logic [3:0] seg_an;
    logic [6:0] seg;
    logic       seg_dp;

    int checks;
    int errors;

`ifdef SEG_CARRY_BLINK_EN
    localparam logic DP_BLINK = 1'b0;
`else
    localparam logic DP_BLINK = 1'b1;
`endif

    seg_scan_disp #(
        .SCAN_DIV    (4),
        .BLINK_TICKS (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (q),
        .z_carry (z_carry),
        .en      (en),
        .dir     (dir),
        .clr     (clr),
        .seg_an  (seg_an),
        .seg     (seg),
        .seg_dp  (seg_dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bit found;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        q       = 4'h5;
        dir     = 1'b1;
        en      = 1'b0;
        z_carry = 1'b0;
        clr     = 1'b0;

        // Reset state
        step(3);
        check("rst_an",  32'(seg_an), 32'h0000000F);
        check("rst_seg", 32'(seg),    32'h7F);
        check("rst_dp",  32'(seg_dp), 32'h1);
        check("rst_cnt", 32'(dut.r_cnt), 32'h0);

        // First tick 4 cycles after release
        reset_n = 1'b1;
        step(3);
        check("pre_tick_an", 32'(seg_an), 32'b1111);
        step(1);
        check("d0_an",  32'(seg_an), 32'b1110);
        check("d0_seg", 32'(seg),    32'b0010010);
        check("d0_dp",  32'(seg_dp), 32'h1);
        step(4);
        check("d1_an",  32'(seg_an), 32'b1101);
        check("d1_seg", 32'(seg),    32'b1000000);
        step(4);
        check("d2_an",  32'(seg_an), 32'b1011);
        check("d2_seg", 32'(seg),    32'b1000000);
        step(4);
        check("d3_an",  32'(seg_an), 32'b0111);
        check("d3_up",  32'(seg),    32'b1000001);
        dir = 1'b0;
        step(1);
        check("d3_dn",  32'(seg),    32'b0100001);
        check("d3_hold_an", 32'(seg_an), 32'b0111);
        step(3);
        check("wrap_d0_an", 32'(seg_an), 32'b1110);

        // Three qualified carry pulses
        en = 1'b1;
        step(1);
        z_carry = 1'b1; step(1);
        z_carry = 1'b0; step(1);
        z_carry = 1'b1; step(1);
        z_carry = 1'b0; step(1);
        z_carry = 1'b1; step(1);
        z_carry = 1'b0; step(1);
        check("cnt3_an",  32'(seg_an), 32'b1101);
        check("cnt3_seg", 32'(seg),    32'b0110000);
        check("cnt3_reg", 32'(dut.r_cnt), 32'd3);
        step(1);
        check("cnt3_hi_an",  32'(seg_an), 32'b1011);
        check("cnt3_hi_seg", 32'(seg),    32'b1000000);

        // Held flag with counter disabled is not counted
        en = 1'b0;
        step(1);
        z_carry = 1'b1;
        step(5);
        z_carry = 1'b0;
        check("held_cnt", 32'(dut.r_cnt), 32'd3);
        check("held_d3",  32'(seg),       32'b0100001);
        step(6);
        check("held_d1_an",  32'(seg_an), 32'b1101);
        check("held_d1_seg", 32'(seg),    32'b0110000);

        // 256 counted carries wrap to 0
        clr = 1'b1;
        step(1);
        check("clr_cnt", 32'(dut.r_cnt), 32'd0);
        clr = 1'b0;
        en  = 1'b1;
        step(1);
        z_carry = 1'b1;
        step(255);
        check("cnt_255", 32'(dut.r_cnt), 32'd255);
        step(1);
        check("cnt_wrap", 32'(dut.r_cnt), 32'd0);
        step(1);
        check("cnt_after_wrap", 32'(dut.r_cnt), 32'd1);
        clr = 1'b1;
        step(1);
        check("clr_wins", 32'(dut.r_cnt), 32'd0);
        clr     = 1'b0;
        z_carry = 1'b0;

        // Reset while digit 2 is shown
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (seg_an === 4'b1011) found = 1'b1;
            else step(1);
        end
        check("find_d2", 32'(found), 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_an",  32'(seg_an), 32'b1111);
        check("mid_rst_seg", 32'(seg),    32'h7F);
        check("mid_rst_cnt", 32'(dut.r_cnt), 32'd0);
        dir = 1'b1;
        step(1);
        reset_n = 1'b1;
        step(3);
        check("mid_pre_an", 32'(seg_an), 32'b1111);
        step(1);
        check("mid_d0_an",  32'(seg_an), 32'b1110);
        check("mid_d0_seg", 32'(seg),    32'b0010010);

        // Decimal point on carry
        check("dp_idle", 32'(seg_dp), 32'h1);
        z_carry = 1'b1;
        step(1);
        z_carry = 1'b0;
        check("dp_same_edge", 32'(seg_dp), 32'h1);
        step(1);
        check("dp_lit_a", 32'(seg_dp), 32'(DP_BLINK));
        step(1);
        check("dp_lit_b", 32'(seg_dp), 32'(DP_BLINK));
        step(1);
        check("dp_d1",     32'(seg_dp), 32'h1);
        check("dp_d1_seg", 32'(seg),    32'b1111001);
        step(12);
        check("dp_next_frame_an", 32'(seg_an), 32'b1110);
        check("dp_expired",       32'(seg_dp), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
